// File: rtl/video_pkg.sv
// Shared types and constants for the video pattern source: pattern modes,
// colour-bar palette and the noise LFSR definition.
package video_pkg;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    GRADIENT = 2'd1,
    CHECKER  = 2'd2,
    NOISE    = 2'd3
  } pattern_mode_t;

  // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  localparam logic [23:0] GREY_RGB  = 24'h808080;
  localparam logic [23:0] LFSR_SEED = 24'hACE1F5;
  // Right-shifting Galois form of x^24 + x^23 + x^22 + x^17 + 1.
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;

  function automatic logic [23:0] lfsrStep(input logic [23:0] state);
    return {1'b0, state[23:1]} ^ (state[0] ? LFSR_TAPS : 24'h000000);
  endfunction

endpackage

// File: rtl/video_timing.sv
// Raster timing: horizontal/vertical counters, active-region flag, raw sync
// windows and frame-boundary strobes for the pattern generator.
module video_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          pixel_clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] x_o,
  output logic [VW-1:0] y_o,
  output logic          active_o,
  output logic          hsync_act_o,
  output logic          vsync_act_o,
  output logic          frame_first_o,
  output logic          frame_end_o
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam int            HS_START = H_ACTIVE + H_FP;
  localparam int            HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int            VS_START = V_ACTIVE + V_FP;
  localparam int            VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] hCnt_q, hCnt_d;
  logic [VW-1:0] vCnt_q, vCnt_d;
  logic          hLast, vLast;

  always_comb begin
    hLast  = (hCnt_q == H_LAST);
    vLast  = (vCnt_q == V_LAST);
    hCnt_d = hLast ? '0 : hCnt_q + HW'(1);
    vCnt_d = vCnt_q;
    if (hLast) begin
      vCnt_d = vLast ? '0 : vCnt_q + VW'(1);
    end
  end

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  // Comparisons are done in 32 bits so window ends equal to the total never overflow.
  assign x_o           = hCnt_q;
  assign y_o           = vCnt_q;
  assign active_o      = (32'(hCnt_q) < H_ACTIVE) && (32'(vCnt_q) < V_ACTIVE);
  assign hsync_act_o   = (32'(hCnt_q) >= HS_START) && (32'(hCnt_q) < HS_END);
  assign vsync_act_o   = (32'(vCnt_q) >= VS_START) && (32'(vCnt_q) < VS_END);
  assign frame_first_o = (hCnt_q == '0) && (vCnt_q == '0);
  assign frame_end_o   = hLast && vLast;

endmodule

// File: rtl/video_pattern_gen.sv
// Raster timing plus test-pattern source (bars, gradient, checker, noise) with
// registered outputs. Define VIDEO_PATTERN_LFSR_EN to build the LFSR noise mode.
module video_pattern_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int SYNC_POL     = 0,
  parameter int CHECKER_LOG2 = 5
) (
  input  logic       pixel_clk_i,
  input  logic       rst_i,
  input  logic [1:0] mode_i,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       de_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       frame_start_o
);

  import video_pkg::*;

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HW       = $clog2(H_TOTAL);
  localparam int   VW       = $clog2(V_TOTAL);
  localparam int   BAR_W    = H_ACTIVE / 8;
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          active, hsAct, vsAct, frameFirst, frameEnd;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) uTiming (
    .pixel_clk_i   (pixel_clk_i),
    .rst_i         (rst_i),
    .x_o           (x),
    .y_o           (y),
    .active_o      (active),
    .hsync_act_o   (hsAct),
    .vsync_act_o   (vsAct),
    .frame_first_o (frameFirst),
    .frame_end_o   (frameEnd)
  );

  // The mode only changes between frames so every frame shows a single pattern.
  pattern_mode_t mode_q;

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= BARS;
    end else if (frameEnd) begin
      mode_q <= pattern_mode_t'(mode_i);
    end
  end

  logic [23:0] noiseRgb;

`ifdef VIDEO_PATTERN_LFSR_EN
  // Reseeding on the last cycle of each frame makes every frame identical.
  logic [23:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (frameEnd) begin
      lfsr_d = LFSR_SEED;
    end else if (active) begin
      lfsr_d = lfsrStep(lfsr_q);
    end
  end

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign noiseRgb = lfsr_q;
`else
  assign noiseRgb = GREY_RGB;
`endif

  logic [2:0]  barIdx;
  logic        checkerOn;
  logic [23:0] patternRgb;
  logic [23:0] rgb_d, rgb_q;

  // Remainder pixels past eight full bars are folded into the last (black) bar.
  always_comb begin
    barIdx = 3'd7;
    if (32'(x) / BAR_W < 7) begin
      barIdx = 3'(32'(x) / BAR_W);
    end
  end

  assign checkerOn = 1'(x >> CHECKER_LOG2) ^ 1'(y >> CHECKER_LOG2);

  always_comb begin
    patternRgb = 24'h000000;
    case (mode_q)
      BARS:     patternRgb = BAR_RGB[barIdx];
      GRADIENT: patternRgb = {8'(x), 8'(y), 8'(8'(x) + 8'(y))};
      CHECKER:  patternRgb = checkerOn ? 24'hFFFFFF : 24'h000000;
      NOISE:    patternRgb = noiseRgb;
      default:  patternRgb = 24'h000000;
    endcase
    rgb_d = active ? patternRgb : 24'h000000;
  end

  logic deQ, hsyncQ, vsyncQ, frameStartQ;

  always_ff @(posedge pixel_clk_i or posedge rst_i) begin
    if (rst_i) begin
      rgb_q       <= 24'h000000;
      deQ         <= 1'b0;
      hsyncQ      <= ~SYNC_ACT;
      vsyncQ      <= ~SYNC_ACT;
      frameStartQ <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      deQ         <= active;
      hsyncQ      <= hsAct ? SYNC_ACT : ~SYNC_ACT;
      vsyncQ      <= vsAct ? SYNC_ACT : ~SYNC_ACT;
      frameStartQ <= frameFirst;
    end
  end

  assign red_o         = rgb_q[23:16];
  assign green_o       = rgb_q[15:8];
  assign blue_o        = rgb_q[7:0];
  assign de_o          = deQ;
  assign hsync_o       = hsyncQ;
  assign vsync_o       = vsyncQ;
  assign frame_start_o = frameStartQ;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a small 24x7 raster, compared
// against a frame-position model derived from the raster and pattern rules.
module tb_video_pattern_gen;

  localparam int HA  = 16;
  localparam int HF  = 2;
  localparam int HSW = 3;
  localparam int HB  = 3;
  localparam int VA  = 4;
  localparam int VF  = 1;
  localparam int VSW = 1;
  localparam int VB  = 1;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VT  = VA + VF + VSW + VB;
  localparam int FT  = HT * VT;

  localparam logic [27:0] RESET_VEC = {4'b0110, 24'h000000};
  localparam logic [23:0] BAR_REF [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic       pixelClk = 1'b0;
  logic       rst      = 1'b1;
  logic [1:0] mode     = 2'd0;
  logic [7:0] red, green, blue;
  logic       de, hsync, vsync, frameStart;

  int          checks   = 0;
  int          failures = 0;
  int          k        = 0;
  int          p        = 0;
  logic [1:0]  curMode  = 2'd0;
  logic [1:0]  nextMode = 2'd0;
  logic [27:0] obs, exp;

`ifdef VIDEO_PATTERN_LFSR_EN
  logic [23:0] noiseTbl [64];
`endif

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .SYNC_POL(0), .CHECKER_LOG2(1)
  ) dut (
    .pixel_clk_i   (pixelClk),
    .rst_i         (rst),
    .mode_i        (mode),
    .red_o         (red),
    .green_o       (green),
    .blue_o        (blue),
    .de_o          (de),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .frame_start_o (frameStart)
  );

  always #5 pixelClk = ~pixelClk;

  function automatic logic [23:0] patternRef(input logic [1:0] m, input int x, input int y);
    logic [23:0] c;
    case (m)
      2'd0:    c = BAR_REF[(x / (HA / 8) > 7) ? 7 : x / (HA / 8)];
      2'd1:    c = {8'(x), 8'(y), 8'(x + y)};
      2'd2:    c = (((x / 2) % 2) != ((y / 2) % 2)) ? 24'hFFFFFF : 24'h000000;
`ifdef VIDEO_PATTERN_LFSR_EN
      default: c = noiseTbl[y * HA + x];
`else
      default: c = 24'h808080;
`endif
    endcase
    return c;
  endfunction

  // Advance one clock; obs holds the DUT outputs, exp the model's view of pixel p.
  task automatic tick();
    int   x, y;
    logic act;
    @(posedge pixelClk);
    #1;
    p = k % FT;
    x = p % HT;
    y = p / HT;
    if (p == 0) curMode = nextMode;
    act = (x < HA) && (y < VA);
    exp = {act, !(x >= HA + HF && x < HA + HF + HSW), !(y >= VA + VF && y < VA + VF + VSW),
           (p == 0), act ? patternRef(curMode, x, y) : 24'h000000};
    obs = {de, hsync, vsync, frameStart, red, green, blue};
    if (p == FT - 1) nextMode = mode;
    k++;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    mode = 2'd0;
    repeat (3) @(posedge pixelClk);
    #1;
    checks++;
    obs = {de, hsync, vsync, frameStart, red, green, blue};
    if (obs !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_held got=%h want=%h", obs, RESET_VEC);
    end
    rst = 1'b0;
    #2;
    checks++;
    obs = {de, hsync, vsync, frameStart, red, green, blue};
    if (obs !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", obs, RESET_VEC);
    end
    k = 0; curMode = 2'd0; nextMode = 2'd0;
  endtask

  task automatic test_timing();
    int deCnt = 0, hsLow = 0, vsLow = 0, fsCnt = 0, lastFs = -1, badGap = 0;
    mode = 2'd0;
    for (int i = 0; i < 3 * FT; i++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL timing_vec k=%0d p=%0d got=%h want=%h", k - 1, p, obs, exp);
      end
      if (de === 1'b1) deCnt++;
      if (hsync === 1'b0) hsLow++;
      if (vsync === 1'b0) vsLow++;
      if (frameStart === 1'b1) begin
        if (lastFs >= 0 && (k - 1 - lastFs) != FT) badGap++;
        lastFs = k - 1;
        fsCnt++;
      end
    end
    checks++;
    if (deCnt !== 3 * HA * VA) begin failures++; $display("FAIL timing_de_count got=%0d want=%0d", deCnt, 3 * HA * VA); end
    checks++;
    if (hsLow !== 3 * VT * HSW) begin failures++; $display("FAIL timing_hsync_low got=%0d want=%0d", hsLow, 3 * VT * HSW); end
    checks++;
    if (vsLow !== 3 * HT * VSW) begin failures++; $display("FAIL timing_vsync_low got=%0d want=%0d", vsLow, 3 * HT * VSW); end
    checks++;
    if (fsCnt !== 3) begin failures++; $display("FAIL timing_fs_count got=%0d want=3", fsCnt); end
    checks++;
    if (badGap !== 0) begin failures++; $display("FAIL timing_fs_period bad_gaps=%0d want=0", badGap); end
  endtask

  task automatic test_bars();
    logic [23:0] want;
    logic        doCheck;
    mode = 2'd0;
    for (int i = 0; i < FT; i++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL bars_vec p=%0d got=%h want=%h", p, obs, exp);
      end
      doCheck = 1'b1;
      want    = 24'h000000;
      case (p)
        0, 1:   want = 24'hFFFFFF;
        2, 3:   want = 24'hFFFF00;
        14, 15: want = 24'h000000;
        16, 20: want = 24'h000000;
        default: doCheck = 1'b0;
      endcase
      if (doCheck) begin
        checks++;
        if ({red, green, blue} !== want) begin
          failures++;
          $display("FAIL bars_pixel p=%0d got=%h want=%h", p, {red, green, blue}, want);
        end
      end
    end
  endtask

  task automatic test_gradient();
    logic seen = 1'b0;
    mode = 2'd1;
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL gradient_vec p=%0d got=%h want=%h", p, obs, exp);
      end
      if (curMode == 2'd1 && p == 3 * HT + 5) begin
        seen = 1'b1;
        checks++;
        if ({red, green, blue} !== 24'h050308) begin
          failures++;
          $display("FAIL gradient_5_3 got=%h want=050308", {red, green, blue});
        end
      end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL gradient_reached got=0 want=1"); end
  endtask

  task automatic test_checker();
    int seen = 0;
    mode = 2'd2;
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL checker_vec p=%0d got=%h want=%h", p, obs, exp);
      end
      if (curMode == 2'd2 && (p == 0 || p == 2 || p == 2 * HT + 2)) begin
        seen++;
        checks++;
        if ({red, green, blue} !== ((p == 2) ? 24'hFFFFFF : 24'h000000)) begin
          failures++;
          $display("FAIL checker_pixel p=%0d got=%h want=%h", p, {red, green, blue},
                   (p == 2) ? 24'hFFFFFF : 24'h000000);
        end
      end
    end
    checks++;
    if (seen < 3) begin failures++; $display("FAIL checker_reached got=%0d want>=3", seen); end
  endtask

  task automatic test_mode_sync();
    logic found = 1'b0;
    logic newFrame = 1'b0;
    mode = 2'd0;
    for (int i = 0; i < 3 * FT && !found; i++) begin
      tick();
      if (curMode == 2'd0 && p == 40) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mode_sync_reached got=0 want=1"); end
    mode = 2'd2;
    for (int i = 0; i < FT; i++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL mode_sync_vec p=%0d got=%h want=%h", p, obs, exp);
      end
      if (p == 0) begin
        newFrame = 1'b1;
        checks++;
        if ({frameStart, red, green, blue} !== {1'b1, 24'h000000}) begin
          failures++;
          $display("FAIL mode_sync_first got=%h want=1000000", {frameStart, red, green, blue});
        end
      end
      if (!newFrame && p == 2 * HT + 2) begin
        checks++;
        if ({red, green, blue} !== 24'hFFFF00) begin
          failures++;
          $display("FAIL mode_sync_old_frame got=%h want=FFFF00", {red, green, blue});
        end
      end
      if (newFrame && p == 2) begin
        checks++;
        if ({red, green, blue} !== 24'hFFFFFF) begin
          failures++;
          $display("FAIL mode_sync_new_frame got=%h want=FFFFFF", {red, green, blue});
        end
      end
    end
  endtask

  task automatic test_random_modes();
    for (int i = 0; i < 5 * FT; i++) begin
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random_vec k=%0d p=%0d mode=%0d got=%h want=%h", k - 1, p, curMode, obs, exp);
      end
    end
  endtask

  task automatic test_noise();
    logic [27:0] frameBuf [2][FT];
    logic        aligned = 1'b0;
    int          diffs   = 0;
    logic [23:0] firstWant;
`ifdef VIDEO_PATTERN_LFSR_EN
    firstWant = 24'hACE1F5;
`else
    firstWant = 24'h808080;
`endif
    mode = 2'd3;
    for (int i = 0; i < 2 * FT && !aligned; i++) begin
      tick();
      if (p == FT - 1 && nextMode == 2'd3) aligned = 1'b1;
    end
    checks++;
    if (!aligned) begin failures++; $display("FAIL noise_aligned got=0 want=1"); end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FT; i++) begin
        tick();
        frameBuf[f][i] = obs;
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL noise_vec frame=%0d p=%0d got=%h want=%h", f, p, obs, exp);
        end
      end
    end
    checks++;
    if (frameBuf[0][0][23:0] !== firstWant) begin
      failures++;
      $display("FAIL noise_first got=%h want=%h", frameBuf[0][0][23:0], firstWant);
    end
    for (int i = 0; i < FT; i++) if (frameBuf[0][i] !== frameBuf[1][i]) diffs++;
    checks++;
    if (diffs !== 0) begin failures++; $display("FAIL noise_repeat differing=%0d want=0", diffs); end
  endtask

  task automatic test_reset_midframe();
    int   target = HT * $urandom_range(0, VA - 1) + $urandom_range(1, HA - 1);
    logic found  = 1'b0;
    for (int i = 0; i < FT + 1 && !found; i++) begin
      tick();
      if (p == target) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL reset_mid_reached got=0 want=1"); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    obs = {de, hsync, vsync, frameStart, red, green, blue};
    if (obs !== RESET_VEC) begin failures++; $display("FAIL reset_mid_async got=%h want=%h", obs, RESET_VEC); end
    @(posedge pixelClk);
    #1;
    rst = 1'b0;
    #3;
    checks++;
    obs = {de, hsync, vsync, frameStart, red, green, blue};
    if (obs !== RESET_VEC) begin failures++; $display("FAIL reset_mid_release got=%h want=%h", obs, RESET_VEC); end
    k = 0; curMode = 2'd0; nextMode = 2'd0;
    tick();
    checks++;
    if ({de, frameStart, red, green, blue} !== {2'b11, 24'hFFFFFF}) begin
      failures++;
      $display("FAIL reset_mid_restart got=%h want=3FFFFFF", {de, frameStart, red, green, blue});
    end
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset_mid_vec p=%0d got=%h want=%h", p, obs, exp);
      end
    end
  endtask

  initial begin
`ifdef VIDEO_PATTERN_LFSR_EN
    begin
      logic [23:0] s;
      s = 24'hACE1F5;
      for (int n = 0; n < 64; n++) begin
        noiseTbl[n] = s;
        s = s[0] ? ((s >> 1) ^ 24'hE10000) : (s >> 1);
      end
    end
`endif
    test_reset();
    test_timing();
    test_bars();
    test_gradient();
    test_checker();
    test_mode_sync();
    test_random_modes();
    test_noise();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
